// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU tile fetch stage.
package npu_pkg;

  localparam int unsigned IMG_W   = 400;
  localparam int unsigned IMG_H   = 400;
  localparam int unsigned TILE    = 10;
  localparam int unsigned TILES_X = IMG_W / TILE;
  localparam int unsigned TILES_Y = IMG_H / TILE;
  localparam int unsigned AW      = 19;
  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 6;
  localparam int unsigned RCW     = $clog2(TILE);

  typedef logic signed [15:0] pixel_t;
  typedef pixel_t [TILE-1:0][TILE-1:0] tile_matrix_t;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StDrain,
    StHold
  } fetch_state_t;

  typedef struct packed {
    logic           vld;
    logic [RCW-1:0] row;
    logic [RCW-1:0] col;
  } cap_tag_t;

endpackage

// File: rtl/npu_tile_addr_gen.sv
// Tile read-address generator: base multiply, then one incremental address per step.
module npu_tile_addr_gen
  import npu_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           calc_i,
  input  logic           step_i,
  input  logic [CW-1:0]  tile_x_i,
  input  logic [CW-1:0]  tile_y_i,
  output logic [AW-1:0]  addr_o,
  output logic [RCW-1:0] row_o,
  output logic [RCW-1:0] col_o,
  output logic           issue_o,
  output logic           last_o
);

  localparam logic [AW-1:0]  RowStride = AW'(TILE * IMG_W);
  localparam logic [AW-1:0]  TileStep  = AW'(TILE);
  localparam logic [AW-1:0]  LineStep  = AW'(IMG_W);
  localparam logic [RCW-1:0] LastIdx   = RCW'(TILE - 1);

  logic [AW-1:0]  addr_d, addr_q;
  logic [AW-1:0]  row_base_d, row_base_q;
  logic [RCW-1:0] row_d, row_q;
  logic [RCW-1:0] col_d, col_q;
  logic           issue_d, issue_q;
  logic [AW-1:0]  base;

  assign base   = AW'(tile_y_i) * RowStride + AW'(tile_x_i) * TileStep;
  assign last_o = issue_q && (row_q == LastIdx) && (col_q == LastIdx);

  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    row_d      = row_q;
    col_d      = col_q;
    issue_d    = issue_q;
    if (calc_i) begin
      addr_d     = base;
      row_base_d = base;
      row_d      = '0;
      col_d      = '0;
      issue_d    = 1'b1;
    end else if (step_i && issue_q) begin
      if (last_o) begin
        // Address holds its final value once the read stream stops.
        issue_d = 1'b0;
      end else if (col_q == LastIdx) begin
        row_base_d = row_base_q + LineStep;
        addr_d     = row_base_q + LineStep;
        row_d      = row_q + 1'b1;
        col_d      = '0;
      end else begin
        addr_d = addr_q + 1'b1;
        col_d  = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      row_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      issue_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      issue_q    <= issue_d;
    end
  end

  assign addr_o  = addr_q;
  assign row_o   = row_q;
  assign col_o   = col_q;
  assign issue_o = issue_q;

endmodule

// File: rtl/npu_tile_fetch.sv
// Streams one TILE x TILE tile from RAM port A into a held signed 16-bit matrix.
module npu_tile_fetch
  import npu_pkg::*;
#(
  parameter int unsigned RdLat = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [CW-1:0] tile_x_i,
  input  logic [CW-1:0] tile_y_i,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_rd_o,
  input  logic [DW-1:0] ram_q_i,
  output logic          busy_o,
  output logic          err_o,
  output logic          tile_valid_o,
  input  logic          tile_ready_i,
  output tile_matrix_t  tile_matrix_o
);

  localparam logic [CW-1:0] TilesX = CW'(TILES_X);
  localparam logic [CW-1:0] TilesY = CW'(TILES_Y);

  fetch_state_t  state_q;
  logic [CW-1:0] tile_x_q, tile_y_q;
  logic          busy_q, err_q, tile_valid_q;
  tile_matrix_t  matrix_q;
  cap_tag_t      tag_q [RdLat];

  logic           ag_calc, ag_step, ag_issue, ag_last;
  logic [RCW-1:0] ag_row, ag_col;
  logic           pipe_busy;

  assign ag_calc = (state_q == StCalc);
  assign ag_step = (state_q == StIssue);

  npu_tile_addr_gen u_addr_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .calc_i   (ag_calc),
    .step_i   (ag_step),
    .tile_x_i (tile_x_q),
    .tile_y_i (tile_y_q),
    .addr_o   (ram_addr_o),
    .row_o    (ag_row),
    .col_o    (ag_col),
    .issue_o  (ag_issue),
    .last_o   (ag_last)
  );

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < RdLat; i++) begin
      pipe_busy = pipe_busy | tag_q[i].vld;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      tile_valid_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if ((tile_x_i < TilesX) && (tile_y_i < TilesY)) begin
              tile_x_q <= tile_x_i;
              tile_y_q <= tile_y_i;
              busy_q   <= 1'b1;
              state_q  <= StCalc;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StCalc:  state_q <= StIssue;
        StIssue: if (ag_last) state_q <= StDrain;
        StDrain: begin
          if (!pipe_busy) begin
            tile_valid_q <= 1'b1;
            state_q      <= StHold;
          end
        end
        StHold: begin
          if (tile_ready_i) begin
            tile_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag stage 0 lines up with the read currently on ram_addr_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RdLat; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: ag_issue, row: ag_row, col: ag_col};
      for (int unsigned i = 1; i < RdLat; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      matrix_q <= '0;
    end else if (tag_q[RdLat-1].vld) begin
      matrix_q[tag_q[RdLat-1].row][tag_q[RdLat-1].col] <= pixel_t'({8'h00, ram_q_i});
    end
  end

  assign ram_rd_o      = ag_issue;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign tile_valid_o  = tile_valid_q;
  assign tile_matrix_o = matrix_q;

endmodule

// File: tb/tb_npu_tile_fetch.sv
// Self-checking bench: RdLat=1 and RdLat=3 instances share stimulus, each with its own RAM model.
module tb_npu_tile_fetch;
  import npu_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] tile_x, tile_y;
  logic          tile_ready;

  logic [AW-1:0] addr1, addr3;
  logic          rd1, rd3, busy1, busy3, err1, err3, tv1, tv3;
  logic [DW-1:0] q1, q3;
  logic [DW-1:0] qp3 [3];
  tile_matrix_t  mat1, mat3;

  int unsigned mul = 1;
  int unsigned add = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  npu_tile_fetch dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .tile_x_i(tile_x), .tile_y_i(tile_y),
    .ram_addr_o(addr1), .ram_rd_o(rd1), .ram_q_i(q1), .busy_o(busy1), .err_o(err1),
    .tile_valid_o(tv1), .tile_ready_i(tile_ready), .tile_matrix_o(mat1)
  );

  npu_tile_fetch #(.RdLat(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .tile_x_i(tile_x), .tile_y_i(tile_y),
    .ram_addr_o(addr3), .ram_rd_o(rd3), .ram_q_i(q3), .busy_o(busy3), .err_o(err3),
    .tile_valid_o(tv3), .tile_ready_i(tile_ready), .tile_matrix_o(mat3)
  );

  // Image content as a function of address; mul/add only change while both DUTs are idle.
  function automatic logic [7:0] pix(input int unsigned a);
    return 8'(a * mul + add);
  endfunction

  always @(posedge clk) begin
    q1     <= pix(32'(addr1));
    qp3[0] <= pix(32'(addr3));
    qp3[1] <= qp3[0];
    qp3[2] <= qp3[1];
  end
  assign q3 = qp3[2];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_tile(input int x, input int y, output int unsigned first_a,
                          output int unsigned last_a);
    int unsigned a1[$];
    int unsigned a3[$];
    int          lat1, lat3, bad1, bad3;
    int unsigned base, ea;
    lat1 = -1;
    lat3 = -1;
    base = 32'(y) * TILE * IMG_W + 32'(x) * TILE;
    @(negedge clk);
    tile_x = CW'(x);
    tile_y = CW'(y);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_on", {busy1, busy3}, 3);
    for (int e = 1; e <= 300 && (lat1 < 0 || lat3 < 0); e++) begin
      @(posedge clk);
      #1;
      if (rd1) a1.push_back(32'(addr1));
      if (rd3) a3.push_back(32'(addr3));
      if (tv1 && lat1 < 0) lat1 = e;
      if (tv3 && lat3 < 0) lat3 = e;
    end
    chk("latency_rdlat1", lat1, TILE * TILE + 3);
    chk("latency_rdlat3", lat3, TILE * TILE + 5);
    chk("n_reads_rdlat1", a1.size(), TILE * TILE);
    chk("n_reads_rdlat3", a3.size(), TILE * TILE);
    bad1 = 0;
    bad3 = 0;
    for (int k = 0; k < TILE * TILE; k++) begin
      ea = base + 32'(k / TILE) * IMG_W + 32'(k % TILE);
      if (k >= a1.size() || a1[k] != ea) bad1++;
      if (k >= a3.size() || a3[k] != ea) bad3++;
    end
    chk("addr_seq_rdlat1", bad1, 0);
    chk("addr_seq_rdlat3", bad3, 0);
    bad1 = 0;
    bad3 = 0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        ea = base + 32'(r) * IMG_W + 32'(c);
        if (mat1[r][c] != {8'h00, pix(ea)}) bad1++;
        if (mat3[r][c] != {8'h00, pix(ea)}) bad3++;
      end
    end
    chk("matrix_rdlat1", bad1, 0);
    chk("matrix_rdlat3", bad3, 0);
    first_a = (a1.size() > 0) ? a1[0] : 32'hFFFF_FFFF;
    last_a  = (a1.size() > 0) ? a1[a1.size()-1] : 32'hFFFF_FFFF;
  endtask

  task automatic accept(input logic with_start);
    @(negedge clk);
    tile_ready = 1'b1;
    if (with_start) begin
      tile_x = '0;
      tile_y = '0;
      start  = 1'b1;
    end
    @(posedge clk);
    #1;
    tile_ready = 1'b0;
    start      = 1'b0;
    chk("accept_tv_clr", {tv1, tv3}, 0);
    chk("accept_busy_clr", {busy1, busy3}, 0);
  endtask

  typedef struct {
    int          x;
    int          y;
    int unsigned first;
    int unsigned last;
    int          m00;
    int          m99;
  } vec_t;

  initial begin
    vec_t         tbl[4];
    int unsigned  fa, la;
    int           bad, rdseen, errseen;
    tile_matrix_t snap1, snap3;

    tbl[0] = '{x: 0,  y: 0,  first: 0,      last: 3609,   m00: 0,   m99: 25};
    tbl[1] = '{x: 39, y: 39, first: 156390, last: 159999, m00: 230, m99: 255};
    tbl[2] = '{x: 5,  y: 7,  first: 28050,  last: 31659,  m00: 146, m99: 171};
    tbl[3] = '{x: 0,  y: 39, first: 156000, last: 159609, m00: 96,  m99: 121};

    rst_n      = 1'b0;
    start      = 1'b0;
    tile_x     = '0;
    tile_y     = '0;
    tile_ready = 1'b0;
    #1;
    chk("reset_outputs", {rd1, rd3, busy1, busy3, err1, err3, tv1, tv3}, 0);
    chk("reset_addr", {addr1, addr3}, 0);
    chk("reset_matrix", (mat1 == '0) && (mat3 == '0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mul = 1;
      add = 0;
      run_tile(tbl[i].x, tbl[i].y, fa, la);
      chk("tbl_first_addr", fa, tbl[i].first);
      chk("tbl_last_addr", la, tbl[i].last);
      chk("tbl_m00_rdlat1", mat1[0][0], tbl[i].m00);
      chk("tbl_m99_rdlat1", mat1[TILE-1][TILE-1], tbl[i].m99);
      chk("tbl_m00_rdlat3", mat3[0][0], tbl[i].m00);
      chk("tbl_m99_rdlat3", mat3[TILE-1][TILE-1], tbl[i].m99);
      accept(1'b0);
    end

    // Out-of-range coordinates on each axis.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tile_x = (i == 0) ? CW'(40) : CW'(3);
      tile_y = (i == 0) ? CW'(3) : CW'(63);
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("err_pulse", {err1, err3}, 3);
      chk("err_no_busy", {busy1, busy3}, 0);
      rdseen  = 0;
      errseen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        if (rd1 | rd3 | busy1 | busy3) rdseen++;
        if (err1 | err3) errseen++;
      end
      chk("err_single_cycle", errseen, 0);
      chk("err_stays_idle", rdseen, 0);
    end

    // Long HOLD with a start pulse, then accept with another start in the same cycle.
    mul = 37;
    add = 11;
    run_tile(10, 20, fa, la);
    snap1   = mat1;
    snap3   = mat3;
    bad     = 0;
    rdseen  = 0;
    errseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tile_x = '0;
      tile_y = '0;
      start  = (i == 5);
      @(posedge clk);
      #1;
      if (mat1 != snap1 || mat3 != snap3 || !tv1 || !tv3 || !busy1 || !busy3) bad++;
      if (rd1 | rd3) rdseen++;
      if (err1 | err3) errseen++;
    end
    start = 1'b0;
    chk("hold_stable", bad, 0);
    chk("hold_no_read", rdseen, 0);
    chk("hold_no_err", errseen, 0);
    accept(1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (busy1 | busy3 | rd1 | rd3 | tv1 | tv3) bad++;
    end
    chk("idle_after_accept", bad, 0);

    // Asynchronous reset in the middle of ISSUE.
    mul = 1;
    add = 0;
    @(negedge clk);
    tile_x = CW'(3);
    tile_y = CW'(4);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (51) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {rd1, rd3, busy1, busy3, err1, err3, tv1, tv3}, 0);
    chk("midrst_addr", {addr1, addr3}, 0);
    chk("midrst_matrix", (mat1 == '0) && (mat3 == '0), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (tv1 | tv3 | rd1 | rd3) bad++;
    end
    chk("midrst_no_resume", bad, 0);
    run_tile(1, 2, fa, la);
    chk("post_rst_first_addr", fa, 8010);
    chk("post_rst_m00", mat1[0][0], 74);
    accept(1'b0);

    // Random tiles over random image content.
    for (int i = 0; i < 6; i++) begin
      mul = $urandom | 1;
      add = $urandom;
      run_tile(int'($urandom_range(0, TILES_X - 1)), int'($urandom_range(0, TILES_Y - 1)),
               fa, la);
      accept(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_tile_fetch.md
Name: npu_tile_fetch

Overview:
- Upstream stage of the NPU: streams one TILE x TILE sub-matrix of the 8-bit source image out of dual-port RAM port A and presents it as a signed 16-bit input matrix.
- Issues one pipelined read per cycle and tolerates the configured RAM read latency, replacing the two-cycle-per-pixel read/wait loop.
- Holds the completed tile under a valid/ready handshake until the NPU controller accepts it.

Parameters:
- IMG_W, 400, image width in pixels; also the row stride in RAM
- IMG_H, 400, image height in pixels
- TILE, 10, tile edge length
- AW, 19, RAM address width
- DW, 8, RAM data width
- RD_LAT, 1, cycles from ram_addr presented to ram_q valid (1..3)

Ports:
- clk  in  1  processing clock (25 MHz domain)
- rst  in  1  asynchronous, active-low reset; block is in reset while rst==0
- start  in  1  single-cycle request to fetch a tile; sampled only in IDLE
- tile_x  in  6  tile column index, latched on accepted start
- tile_y  in  6  tile row index, latched on accepted start
- ram_addr  out  AW  port A read address (registered)
- ram_rd  out  1  high in every cycle ram_addr carries a live read
- ram_q  in  DW  port A read data
- busy  out  1  high from accepted start until tile accepted
- err  out  1  one-cycle pulse: start rejected because of out-of-range coordinate
- tile_valid  out  1  tile_matrix complete and stable
- tile_ready  in  1  consumer accepts the tile in a cycle where tile_valid==1
- tile_matrix  out  TILE x TILE x 16 signed  element [r][c] = {8'h00, pixel}

Behaviour:
- Reset (rst==0, async): state IDLE. ram_addr=0, ram_rd=0, busy=0, err=0, tile_valid=0, every tile_matrix element 0, pipeline tags cleared. A reset taken mid-fetch aborts the fetch; no partial tile is ever flagged valid.
- States: IDLE -> CALC -> ISSUE -> DRAIN -> HOLD -> IDLE.
- IDLE: start==1 with tile_x < IMG_W/TILE and tile_y < IMG_H/TILE:
  - latch both coordinates, busy<=1, go to CALC.
  - Out-of-range coordinate: err pulses for one cycle and the block stays in IDLE.
- CALC (1 cycle):
  - base <= tile_y*TILE*IMG_W + tile_x*TILE, the only multiply.
  - ram_addr <= base, ram_rd <= 1, r=c=0.
- ISSUE (TILE*TILE cycles): one address per cycle.
  - ram_addr for element (r,c) = base + r*IMG_W + c.
  - Generated incrementally: c+1 within a row; at c==TILE-1, row_base += IMG_W and c=0.
  - After the last element (r=c=TILE-1) is issued, ram_rd<=0 and go to DRAIN.
- Capture pipeline: an RD_LAT-deep shift register carries {valid, r, c} alongside each read; when a tag exits, tile_matrix[r][c] <= {8'h00, ram_q}.
- DRAIN: wait until the pipeline is empty (RD_LAT cycles), then tile_valid<=1 and go to HOLD.
- Latency: tile_valid rises TILE*TILE+RD_LAT+2 clock edges after the edge that samples start (103 with defaults).
- HOLD:
  - tile_matrix is frozen while tile_valid==1.
  - tile_ready==1: tile_valid<=0, busy<=0, go to IDLE.
  - tile_ready asserted outside HOLD is ignored.
- start while busy==1, including the HOLD cycle that is accepted, is ignored with no err pulse; the controller must re-issue start.
- Address arithmetic uses AW bits unsigned. The maximum address is (IMG_H*IMG_W)-1 (159999 with defaults), so no wrap occurs for legal tiles.
- ram_addr holds its last value when ram_rd==0. The block never drives a RAM write.

Decomposition:
- npu_pkg holds:
  - constants IMG_W, IMG_H, TILE, TILES_X = IMG_W/TILE, TILES_Y = IMG_H/TILE
  - typedef tile_matrix_t, a signed 16-bit TILE x TILE array
  - fetch_state_t enum
- One natural sub-module, npu_tile_addr_gen: owns the base multiply, the incremental row/column counters, and the issue/last flags. The parent keeps the FSM, tag pipeline and matrix registers.

Test Plan:
- Reset, then start with tile (0,0) and a RAM model filled with pixel = addr mod 256:
  - ram_addr runs 0..9, 400..409, ..., 3600..3609.
  - tile_valid rises at edge 103; tile_matrix[9][9] = 3609 mod 256 = 25.
- Tile (39,39): first address 156390, last 159999; tile_matrix[0][0] = 156390 mod 256 = 230.
- start with tile_x=40 -> err high for exactly 1 cycle, busy stays 0, no ram_rd.
- Hold tile_ready low for 20 cycles after tile_valid:
  - tile_matrix stays unchanged and a start pulse during HOLD is ignored.
  - tile_ready=1 -> tile_valid=0 and busy=0 on the next edge.
- Drive rst low at ISSUE cycle 50 -> all outputs 0 immediately (asynchronous). After release, a fresh tile (1,2) fetch returns the correct data with no stale elements.
- RD_LAT=3 build, tile (5,7) -> tile_valid at edge 105 and all 100 elements match the RAM model.
